// File: rtl/amba_pkg.sv
// Shared types and sizing for the AHB bus arbiter and its round-robin picker.
// Pure declarations: no logic, no latency, no backpressure.
package amba_pkg;

  localparam int MWIDTH       = 4;
  localparam int M_ADDR_WIDTH = $clog2(MWIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    PARK,
    OWNED,
    LOCKED
  } arb_state_t;

endpackage

// File: rtl/amba_arbiter_rr.sv
// Combinational round-robin picker: first request above i_ptr, wrapping, i_ptr itself last.
// Zero latency; no backpressure (pure function of the inputs).
module rr_pick
  import amba_pkg::*;
#(
  parameter  int MWIDTH       = 4,
  localparam int M_ADDR_WIDTH = $clog2(MWIDTH)
) (
  input  logic [MWIDTH-1:0]       i_req,
  input  logic [M_ADDR_WIDTH-1:0] i_ptr,
  output logic [M_ADDR_WIDTH-1:0] o_win,
  output logic                    o_vld
);

  always_comb begin
    logic [M_ADDR_WIDTH:0]   sum;
    logic [M_ADDR_WIDTH-1:0] idx;
    o_win = '0;
    o_vld = 1'b0;
    sum   = '0;
    idx   = '0;
    // One extra bit on sum keeps the wrap correct for non-power-of-two MWIDTH.
    for (int k = 1; k <= MWIDTH; k++) begin
      sum = {1'b0, i_ptr} + (M_ADDR_WIDTH+1)'(k);
      if (sum >= (M_ADDR_WIDTH+1)'(MWIDTH)) begin
        sum = sum - (M_ADDR_WIDTH+1)'(MWIDTH);
      end
      idx = sum[M_ADDR_WIDTH-1:0];
      if (!o_vld && i_req[idx]) begin
        o_win = idx;
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/amba_arbiter.sv
// Round-robin AHB arbiter with lock, burst protection, tenure preemption and parking; grant one cycle after decision.
// hready=0 freezes every register, so a stalled slave holds grant and data-phase owner in place.
module amba_arbiter
  import amba_pkg::*;
#(
  parameter  int MWIDTH         = 4,
  parameter  int DEFAULT_MASTER = 0,
  parameter  int MAX_TENURE     = 16,
  localparam int M_ADDR_WIDTH   = $clog2(MWIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MWIDTH-1:0]       hbusreq_mst_n,
  input  logic [MWIDTH-1:0]       hlock_mst_n,
  input  logic [2*MWIDTH-1:0]     htrans_mst_n,
  input  logic                    hready,
  output logic [MWIDTH-1:0]       hgrant_mst_n,
  output logic [M_ADDR_WIDTH-1:0] hmaster,
  output logic [M_ADDR_WIDTH-1:0] hmaster_d,
  output logic                    hmastlock
);

  localparam int CW = (MAX_TENURE < 1) ? 1 : $clog2(MAX_TENURE + 1);
  localparam logic [M_ADDR_WIDTH-1:0] DEF_IDX   = M_ADDR_WIDTH'(DEFAULT_MASTER);
  localparam logic [MWIDTH-1:0]       DEF_GRANT = MWIDTH'(1) << DEFAULT_MASTER;

  logic [MWIDTH-1:0]       r_grant;
  logic [M_ADDR_WIDTH-1:0] r_hmaster;
  logic [M_ADDR_WIDTH-1:0] r_hmaster_d;
  logic                    r_hmastlock;
  logic [M_ADDR_WIDTH-1:0] r_ptr;
  logic [CW-1:0]           r_cnt;
  arb_state_t              r_state;

  arb_state_t              w_state_nxt;
  htrans_t                 w_own_trans;
  logic                    w_own_req;
  logic                    w_own_lock;
  logic                    w_others_req;
  logic                    w_force;
  logic                    w_handover;
  logic                    w_move;
  logic                    w_cnt_inc;
  logic [M_ADDR_WIDTH-1:0] w_pick;
  logic                    w_pick_vld;
  logic [M_ADDR_WIDTH-1:0] w_winner;

  rr_pick #(.MWIDTH(MWIDTH)) u_pick (
    .i_req (hbusreq_mst_n),
    .i_ptr (r_ptr),
    .o_win (w_pick),
    .o_vld (w_pick_vld)
  );

  always_comb begin
    w_own_trans = IDLE;
    for (int i = 0; i < MWIDTH; i++) begin
      if (r_hmaster == M_ADDR_WIDTH'(i)) begin
        w_own_trans = htrans_t'(htrans_mst_n[2*i +: 2]);
      end
    end
  end

  assign w_own_req    = hbusreq_mst_n[r_hmaster];
  assign w_own_lock   = hlock_mst_n[r_hmaster];
  assign w_others_req = |(hbusreq_mst_n & ~r_grant);
  assign w_winner     = w_pick_vld ? w_pick : DEF_IDX;

  // Forced preemption never interrupts a BUSY beat or anything inside a locked sequence.
  assign w_force = (MAX_TENURE != 0) && (r_cnt >= CW'(MAX_TENURE)) && w_others_req &&
                   (w_own_trans != BUSY) && (r_state != LOCKED);

  assign w_handover = hready && !w_own_lock &&
                      ((w_own_trans == IDLE) ||
                       (!w_own_req && (w_own_trans != SEQ) && (w_own_trans != BUSY)) ||
                       w_force);

  assign w_move    = w_handover && (w_winner != r_hmaster);
  assign w_cnt_inc = hready && ((w_own_trans == NONSEQ) || (w_own_trans == SEQ)) &&
                     (r_cnt < CW'(MAX_TENURE));

  always_comb begin
    w_state_nxt = r_state;
    if (hready && w_own_lock) begin
      w_state_nxt = LOCKED;
    end else if (w_handover) begin
      w_state_nxt = w_pick_vld ? OWNED : PARK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= PARK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant     <= DEF_GRANT;
      r_hmaster   <= DEF_IDX;
      r_hmaster_d <= DEF_IDX;
      r_hmastlock <= 1'b0;
      r_ptr       <= DEF_IDX;
      r_cnt       <= '0;
    end else if (hready) begin
      r_hmaster_d <= r_hmaster;
      r_hmastlock <= w_own_lock;
      if (w_move) begin
        r_grant           <= '0;
        r_grant[w_winner] <= 1'b1;
        r_hmaster         <= w_winner;
        r_ptr             <= w_winner;
        r_cnt             <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign hgrant_mst_n = r_grant;
  assign hmaster      = r_hmaster;
  assign hmaster_d    = r_hmaster_d;
  assign hmastlock    = r_hmastlock;

endmodule

// File: tb/tb_amba_arbiter.sv
// Directed and random stimulus for amba_arbiter, checked against a queue-free behavioural model.
module tb_amba_arbiter;
  import amba_pkg::*;

  localparam int N    = 4;
  localparam int DEF  = 0;
  localparam int MAXT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] lock;
  logic [7:0] trans;
  logic       rdy;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic [1:0] hmaster_d;
  logic       hmastlock;

  int n_vec = 0;
  int n_err = 0;

  int m_owner, m_owner_d, m_ptr, m_cnt;
  bit m_mlock, m_locked;

  always #5 clk = ~clk;

  amba_arbiter #(.MWIDTH(N), .DEFAULT_MASTER(DEF), .MAX_TENURE(MAXT)) dut (
    .clk           (clk),
    .rst           (rst),
    .hbusreq_mst_n (req),
    .hlock_mst_n   (lock),
    .htrans_mst_n  (trans),
    .hready        (rdy),
    .hgrant_mst_n  (hgrant),
    .hmaster       (hmaster),
    .hmaster_d     (hmaster_d),
    .hmastlock     (hmastlock)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] tr_of(input int i);
    logic [7:0] v;
    v = trans >> (2 * i);
    return v[1:0];
  endfunction

  function automatic logic [7:0] tx(input int m, input htrans_t t);
    logic [7:0] v;
    v = 8'(t);
    return v << (2 * m);
  endfunction

  // Reference: the arbitration rules applied once per clock edge on integers.
  task automatic model_step();
    htrans_t ot;
    bit ol, orq, others, ok, found;
    int win, idx;
    if (rst) begin
      m_owner = DEF; m_owner_d = DEF; m_ptr = DEF; m_cnt = 0; m_mlock = 0; m_locked = 0;
      return;
    end
    if (!rdy) return;
    ot  = htrans_t'(tr_of(m_owner));
    ol  = lock[m_owner];
    orq = req[m_owner];
    others = 0;
    for (int i = 0; i < N; i++) if (i != m_owner && req[i]) others = 1;
    ok = !ol && (ot == IDLE || (!orq && ot != SEQ && ot != BUSY) ||
                 (MAXT != 0 && m_cnt >= MAXT && others && ot != BUSY && !m_locked));
    win = DEF; found = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (m_ptr + k) % N;
      if (!found && req[idx]) begin win = idx; found = 1; end
    end
    m_owner_d = m_owner;
    m_mlock   = ol;
    if (ol) m_locked = 1;
    else if (ok) m_locked = 0;
    if (ok && win != m_owner) begin
      m_owner = win; m_ptr = win; m_cnt = 0;
    end else if (ot == NONSEQ || ot == SEQ) begin
      m_cnt = (m_cnt + 1 > MAXT) ? MAXT : m_cnt + 1;
    end
  endtask

  task automatic check_outs();
    check_val("hgrant",    32'(hgrant),    32'(1) << m_owner);
    check_val("hmaster",   32'(hmaster),   32'(m_owner));
    check_val("hmaster_d", 32'(hmaster_d), 32'(m_owner_d));
    check_val("hmastlock", 32'(hmastlock), 32'(m_mlock));
  endtask

  task automatic cyc(input logic [3:0] rq, input logic [3:0] lk, input logic [7:0] tr,
                     input logic rd, input logic rs);
    req = rq; lock = lk; trans = tr; rdy = rd; rst = rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outs();
  endtask

  initial begin
    int prev, ph, n;
    bit found;
    m_owner = DEF; m_owner_d = DEF; m_ptr = DEF; m_cnt = 0; m_mlock = 0; m_locked = 0;

    // Reset, then parked with no requests.
    cyc(4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1);
    cyc(4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1);
    for (int c = 0; c < 10; c++) begin
      cyc(4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0);
      check_val("park_grant", 32'(hgrant), 32'd1);
    end

    // Masters 1..3 each do NONSEQ then IDLE: grant rotates 1,2,3,1,...
    prev = m_owner; ph = 0;
    for (int c = 0; c < 16; c++) begin
      if (m_owner != prev) begin
        if (prev != 0) check_val("rotate", 32'(hmaster), 32'((prev % 3) + 1));
        prev = m_owner; ph = 0;
      end
      cyc(4'b1110, 4'b0000, (m_owner == 0) ? 8'h00 : tx(m_owner, ph ? IDLE : NONSEQ), 1'b1, 1'b0);
      ph = 1;
    end

    // Master 2 burst with a two-cycle wait state, master 1 waiting.
    cyc(4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0);
    for (int c = 0; c < 8 && m_owner != 2; c++) cyc(4'b0100, 4'b0000, 8'h00, 1'b1, 1'b0);
    check_val("own2", 32'(hmaster), 32'd2);
    cyc(4'b0110, 4'b0000, tx(2, NONSEQ), 1'b1, 1'b0);
    cyc(4'b0110, 4'b0000, tx(2, SEQ), 1'b0, 1'b0);
    cyc(4'b0110, 4'b0000, tx(2, SEQ), 1'b0, 1'b0);
    check_val("burst_hold", 32'(hmaster), 32'd2);
    cyc(4'b0110, 4'b0000, tx(2, SEQ), 1'b1, 1'b0);
    cyc(4'b0110, 4'b0000, tx(2, SEQ), 1'b1, 1'b0);
    cyc(4'b0110, 4'b0000, tx(2, SEQ), 1'b1, 1'b0);
    check_val("burst_end_hold", 32'(hmaster), 32'd2);
    cyc(4'b0110, 4'b0000, tx(2, IDLE), 1'b1, 1'b0);
    check_val("burst_handover", 32'(hgrant), 32'b0010);

    // Master 3 locked sequence, master 1 waiting.
    cyc(4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0);
    for (int c = 0; c < 8 && m_owner != 3; c++) cyc(4'b1000, 4'b0000, 8'h00, 1'b1, 1'b0);
    check_val("own3", 32'(hmaster), 32'd3);
    for (int c = 0; c < 8; c++) begin
      cyc(4'b1010, 4'b1000, tx(3, NONSEQ), 1'b1, 1'b0);
      check_val("lock_owner", 32'(hmaster), 32'd3);
      check_val("lock_flag", 32'(hmastlock), 32'd1);
    end
    cyc(4'b1010, 4'b0000, tx(3, IDLE), 1'b1, 1'b0);
    check_val("unlock_handover", 32'(hmaster), 32'd1);

    // Master 1 streams, master 2 waiting: forced handover after MAXT accepted beats.
    n = 0; found = 0;
    for (int c = 0; c < 12 && !found; c++) begin
      cyc(4'b0110, 4'b0000, tx(1, (c == 0) ? NONSEQ : SEQ), 1'b1, 1'b0);
      n++;
      if (hmaster == 2'd2) found = 1;
    end
    check_val("force_seen", 32'(found), 32'd1);
    check_val("force_edge", 32'(n), 32'(MAXT + 1));

    // Reset mid-burst while stalled.
    cyc(4'b0110, 4'b0000, tx(2, NONSEQ), 1'b1, 1'b0);
    cyc(4'b0110, 4'b0000, tx(2, SEQ), 1'b1, 1'b0);
    cyc(4'b0110, 4'b0000, tx(2, SEQ), 1'b0, 1'b1);
    check_val("rst_grant", 32'(hgrant), 32'd1);
    check_val("rst_hmaster", 32'(hmaster), 32'd0);
    check_val("rst_hmaster_d", 32'(hmaster_d), 32'd0);
    check_val("rst_state", 32'(dut.r_state), 32'(PARK));
    cyc(4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      cyc(4'($urandom),
          ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000,
          8'($urandom),
          ($urandom_range(0, 4) != 0),
          ($urandom_range(0, 199) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
